// File: rtl/idelay_tap_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : idelay_tap_scanner_if
// Brief    : Control, result and IDELAYE2 pin bundle for idelay_tap_scanner.
// Revision : 1.0 - initial release
// ============================================================================
interface idelay_tap_scanner_if #(
    parameter int SAMPLES = 16
) ();
    localparam int CW = $clog2(SAMPLES + 1);

    logic          cal_rdy;
    logic          start;
    logic          dly_q;
    logic [4:0]    dly_cntvalue;
    logic          dly_ld;
    logic          busy;
    logic          res_valid;
    logic [4:0]    res_tap;
    logic [CW-1:0] res_ones;
    logic          done;
    logic          aborted;
    logic          edge_found;
    logic [4:0]    edge_tap;

    modport master (
        output cal_rdy, start, dly_q,
        input  dly_cntvalue, dly_ld, busy, res_valid, res_tap, res_ones,
               done, aborted, edge_found, edge_tap
    );

    modport slave (
        input  cal_rdy, start, dly_q,
        output dly_cntvalue, dly_ld, busy, res_valid, res_tap, res_ones,
               done, aborted, edge_found, edge_tap
    );
endinterface
`default_nettype wire

// File: rtl/idelay_tap_scanner.sv
`default_nettype none
// ============================================================================
// Module   : idelay_tap_scanner
// Brief    : Steps an IDELAYE2 through all 32 taps, counts sampled ones per tap
//            and reports the first tap whose majority level differs from tap 0.
// Revision : 1.0 - initial release
// ============================================================================
module idelay_tap_scanner #(
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLES       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    idelay_tap_scanner_if.slave   bus
);
    localparam int              CW            = $clog2(SAMPLES + 1);
    localparam logic [8:0]      c_settle_last = 9'(SETTLE_CYCLES - 1);
    localparam logic [8:0]      c_sample_last = 9'(SAMPLES - 1);
    localparam logic [CW-1:0]   c_half        = CW'(SAMPLES / 2);
    localparam logic [4:0]      c_last_tap    = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_REPORT = 3'd4,
        S_FINISH = 3'd5,
        S_ABORT  = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_sync;
    logic [8:0]    r_cnt;
    logic [CW-1:0] r_ones;
    logic [4:0]    r_tap;
    logic          r_ref_level;
    logic          r_edge_found;
    logic [4:0]    r_edge_tap;

    logic          w_accept;
    logic          w_cal_lost;
    logic          w_level;
    logic          w_report;
    logic          w_busy;
    logic          w_ld;
    logic          w_done;
    logic          w_aborted;

    // dly_q has no fixed phase relation to clk, so only r_sync[1] is used
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], bus.dly_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_cal_lost  = 1'b0;
        w_report    = 1'b0;
        w_busy      = 1'b0;
        w_ld        = 1'b0;
        w_done      = 1'b0;
        w_aborted   = 1'b0;
        w_level     = (r_ones > c_half);

        case (r_state)
            S_IDLE: begin
                if (bus.start && bus.cal_rdy) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_busy      = 1'b1;
                w_ld        = 1'b1;
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                w_busy = 1'b1;
                if (r_cnt == c_settle_last) begin
                    w_state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                w_busy = 1'b1;
                if (r_cnt == c_sample_last) begin
                    w_state_nxt = S_REPORT;
                end
            end
            S_REPORT: begin
                w_busy      = 1'b1;
                w_report    = bus.cal_rdy;
                w_state_nxt = (r_tap == c_last_tap) ? S_FINISH : S_LOAD;
            end
            S_FINISH: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_ABORT: begin
                w_done      = 1'b1;
                w_aborted   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Losing calibration overrides every active step, including REPORT
        if (w_busy && !bus.cal_rdy) begin
            w_cal_lost  = 1'b1;
            w_state_nxt = S_ABORT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_ones       <= '0;
            r_tap        <= '0;
            r_ref_level  <= 1'b0;
            r_edge_found <= 1'b0;
            r_edge_tap   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_tap        <= '0;
                        r_edge_found <= 1'b0;
                        r_edge_tap   <= '0;
                    end
                end
                S_LOAD: begin
                    r_cnt  <= '0;
                    r_ones <= '0;
                end
                S_SETTLE: begin
                    r_cnt <= (r_cnt == c_settle_last) ? 9'd0 : r_cnt + 9'd1;
                end
                S_SAMPLE: begin
                    r_cnt <= r_cnt + 9'd1;
                    if (r_sync[1]) begin
                        r_ones <= r_ones + CW'(1);
                    end
                end
                S_REPORT: begin
                    if (w_report) begin
                        if (r_tap == 5'd0) begin
                            r_ref_level <= w_level;
                        end else if (!r_edge_found && (w_level != r_ref_level)) begin
                            r_edge_found <= 1'b1;
                            r_edge_tap   <= r_tap;
                        end
                        if (r_tap != c_last_tap) begin
                            r_tap <= r_tap + 5'd1;
                        end
                    end
                end
                default: begin
                end
            endcase

            if (w_cal_lost) begin
                r_tap        <= '0;
                r_edge_found <= 1'b0;
                r_edge_tap   <= '0;
            end
        end
    end

    assign bus.dly_cntvalue = r_tap;
    assign bus.dly_ld       = w_ld;
    assign bus.busy         = w_busy;
    assign bus.res_valid    = w_report;
    assign bus.res_tap      = r_tap;
    assign bus.res_ones     = r_ones;
    assign bus.done         = w_done;
    assign bus.aborted      = w_aborted;
    assign bus.edge_found   = r_edge_found;
    assign bus.edge_tap     = r_edge_tap;

endmodule
`default_nettype wire

// File: tb/tb_idelay_tap_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_idelay_tap_scanner
// Brief    : Directed self-checking bench for idelay_tap_scanner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idelay_tap_scanner;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    idelay_tap_scanner_if #(.SAMPLES(16)) bus ();

    idelay_tap_scanner #(
        .SETTLE_CYCLES (8),
        .SAMPLES       (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // 0: dly_q stuck high, 1: high once loaded tap >= 13, 2: toggles every clk
    int   mode = 0;
    logic lat  = 1'b0;

    always @(negedge clk) begin
        case (mode)
            0: bus.dly_q = 1'b1;
            1: begin
                if (bus.dly_ld) lat = (bus.dly_cntvalue >= 5'd13);
                bus.dly_q = lat;
            end
            default: bus.dly_q = ~bus.dly_q;
        endcase
    end

    int         n_res  = 0;
    int         n_done = 0;
    int         n_ld   = 0;
    logic [4:0] log_tap  [512];
    logic [4:0] log_ones [512];

    always @(negedge clk) begin
        if (bus.res_valid && n_res < 512) begin
            log_tap[n_res]  = bus.res_tap;
            log_ones[n_res] = bus.res_ones;
            n_res++;
        end
        if (bus.done)   n_done++;
        if (bus.dly_ld) n_ld++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Returns the cycle count where the start-pulse cycle is cycle 0
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!bus.done && cyc < 2000) begin
            tick();
            cyc++;
        end
        check("done_seen", bus.done, 1);
    endtask

    task automatic wait_tap_load(input logic [4:0] tap);
        int k;
        k = 0;
        while (!(bus.dly_ld && bus.dly_cntvalue == tap) && k < 1000) begin
            tick();
            k++;
        end
        check($sformatf("load_tap%0d_seen", tap), bus.dly_ld, 1);
    endtask

    task automatic verify_scan(input int base, input int kind);
        logic [4:0] exp_ones;
        for (int i = 0; i < 32; i++) begin
            case (kind)
                0:       exp_ones = 5'd16;
                1:       exp_ones = (i >= 13) ? 5'd16 : 5'd0;
                default: exp_ones = 5'd8;
            endcase
            check($sformatf("k%0d_tap_idx%0d", kind, i), log_tap[base + i], i);
            check($sformatf("k%0d_ones_tap%0d", kind, i), log_ones[base + i], exp_ones);
        end
    endtask

    int base;
    int cyc;
    int snap;

    initial begin
        rst_n       = 1'b0;
        bus.cal_rdy = 1'b0;
        bus.start   = 1'b0;
        repeat (3) tick();
        check("rst_busy",       bus.busy, 0);
        check("rst_done",       bus.done, 0);
        check("rst_ld",         bus.dly_ld, 0);
        check("rst_res_valid",  bus.res_valid, 0);
        check("rst_cntvalue",   bus.dly_cntvalue, 0);
        check("rst_edge_found", bus.edge_found, 0);
        check("rst_edge_tap",   bus.edge_tap, 0);
        check("rst_res_ones",   bus.res_ones, 0);
        check("rst_aborted",    bus.aborted, 0);
        rst_n       = 1'b1;
        bus.cal_rdy = 1'b1;
        tick();

        // Constant-high input: every tap saturates, no edge
        mode = 0;
        base = n_res;
        pulse_start();
        check("a_busy_after_start", bus.busy, 1);
        wait_done(cyc);
        check("a_done_cycle", cyc, 833);
        check("a_aborted", bus.aborted, 0);
        check("a_edge_found", bus.edge_found, 0);
        check("a_edge_tap", bus.edge_tap, 0);
        check("a_busy_at_done", bus.busy, 0);
        check("a_result_count", n_res - base, 32);
        verify_scan(base, 0);
        tick();
        check("a_done_one_cycle", bus.done, 0);

        // Step at tap 13
        mode = 1;
        base = n_res;
        pulse_start();
        wait_done(cyc);
        check("b_done_cycle", cyc, 833);
        check("b_result_count", n_res - base, 32);
        check("b_edge_found", bus.edge_found, 1);
        check("b_edge_tap", bus.edge_tap, 13);
        verify_scan(base, 1);
        repeat (5) tick();
        check("b_edge_found_held", bus.edge_found, 1);
        check("b_edge_tap_held", bus.edge_tap, 13);

        // Half ones per tap: a tie is level 0, so no edge
        mode = 2;
        base = n_res;
        pulse_start();
        wait_done(cyc);
        check("c_result_count", n_res - base, 32);
        check("c_edge_found", bus.edge_found, 0);
        verify_scan(base, 2);

        // start ignored without calibration
        bus.cal_rdy = 1'b0;
        snap = n_ld;
        pulse_start();
        repeat (5) tick();
        check("d_busy_no_cal", bus.busy, 0);
        check("d_ld_no_cal", n_ld - snap, 0);
        bus.cal_rdy = 1'b1;
        mode = 0;
        base = n_res;
        pulse_start();
        wait_done(cyc);
        check("d_done_cycle", cyc, 833);
        check("d_result_count", n_res - base, 32);

        // Abort during tap 5 SAMPLE
        base = n_res;
        pulse_start();
        wait_tap_load(5'd5);
        repeat (12) tick();
        check("e_busy_in_sample", bus.busy, 1);
        bus.cal_rdy = 1'b0;
        tick();
        check("e_done", bus.done, 1);
        check("e_aborted", bus.aborted, 1);
        check("e_busy", bus.busy, 0);
        check("e_edge_found", bus.edge_found, 0);
        check("e_cntvalue", bus.dly_cntvalue, 0);
        check("e_result_count", n_res - base, 5);
        tick();
        check("e_done_one_cycle", bus.done, 0);
        bus.cal_rdy = 1'b1;

        // Abort in the REPORT cycle of tap 14, after the edge at 13 was found
        mode = 1;
        base = n_res;
        pulse_start();
        wait_tap_load(5'd14);
        repeat (25) tick();
        check("f_report_valid", bus.res_valid, 1);
        check("f_report_tap", bus.res_tap, 14);
        check("f_edge_before_abort", bus.edge_found, 1);
        bus.cal_rdy = 1'b0;
        #1;
        check("f_report_suppressed", bus.res_valid, 0);
        tick();
        check("f_done", bus.done, 1);
        check("f_aborted", bus.aborted, 1);
        check("f_edge_found", bus.edge_found, 0);
        check("f_result_count", n_res - base, 14);
        bus.cal_rdy = 1'b1;

        // Reset mid-scan at tap 20, then a clean rescan
        mode = 0;
        pulse_start();
        wait_tap_load(5'd20);
        repeat (3) tick();
        snap  = n_done;
        rst_n = 1'b0;
        #1;
        check("g_rst_busy", bus.busy, 0);
        check("g_rst_cntvalue", bus.dly_cntvalue, 0);
        check("g_rst_res_tap", bus.res_tap, 0);
        check("g_rst_res_ones", bus.res_ones, 0);
        repeat (3) tick();
        check("g_no_done_on_reset", n_done - snap, 0);
        rst_n = 1'b1;
        mode  = 1;
        base  = n_res;
        pulse_start();
        wait_done(cyc);
        check("g_done_cycle", cyc, 833);
        check("g_result_count", n_res - base, 32);
        check("g_edge_tap", bus.edge_tap, 13);
        verify_scan(base, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
